load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low (0 = reset).
REQ-003 SHALL have port req_valid, input, 1: execute stage presents a memory op.
REQ-004 SHALL have port req_ready, output, 1: unit can accept an op (IDLE only).
REQ-005 SHALL have port req_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3: RV64 size/sign code.
REQ-007 SHALL have port addr, input, 64: ALU result (effective byte address).
REQ-008 SHALL have port store_data, input, 64: rs2 data.
REQ-009 SHALL have port rd, input, 5: load destination register.
REQ-010 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 64, bits[2:0]=0), mem_wdata (out, 64), mem_wstrb (out, 8): data-memory request.
REQ-011 SHALL have ports mem_ack (in, 1) and mem_rdata (in, 64): memory completion; rdata valid with ack.
REQ-012 SHALL have ports resp_valid (out, 1), resp_err (out, 1), wb_en (out, 1), wb_rd (out, 5), wb_data (out, 64): result toward the register file write port.

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, DONE; req_ready=1 only in IDLE.
REQ-014 SHALL accept on req_valid&req_ready; latch addr, store_data, funct3, req_store, rd; go to ACCESS (or DONE on error).
REQ-015 SHALL, in ACCESS, hold mem_req=1 and all mem_* outputs stable until the cycle mem_ack=1.
REQ-016 SHALL, on mem_ack in ACCESS, register the response and go to DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 SHALL assert resp_valid only in DONE; min latency accept-edge to resp_valid = 2 cycles; no back-to-back accept (next accept the cycle after DONE).
REQ-018 SHALL decode loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores: 000 SB, 001 SH, 010 SW, 011 SD.
REQ-019 SHALL treat load funct3=111 or store funct3[2]=1 as illegal: no mem_req, DONE with resp_err=1, wb_en=0.
REQ-020 SHALL drive mem_addr = {addr[63:3],3'b000}, offset = addr[2:0].
REQ-021 SHALL, for stores, set mem_we=1, mem_wstrb = size mask (0x01/0x03/0x0F/0xFF) << offset, mem_wdata = store_data << (8*offset).
REQ-022 SHALL, for loads, set mem_we=0, mem_wstrb=0, wb_data = (mem_rdata >> 8*offset) truncated to size, sign- or zero-extended per funct3.
REQ-023 SHALL assert wb_en in DONE only for a successful load with rd != 0; wb_rd = latched rd.
REQ-024 SHALL ignore mem_ack outside ACCESS and ignore req_valid outside IDLE.
REQ-025 SHALL define misaligned as offset not a multiple of access size (bytes never misaligned).

Reset
REQ-026 SHALL, while reset=0, force FSM to IDLE and req_ready=1; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_err, wb_en, wb_rd, wb_data all 0.
REQ-027 SHALL drop mem_req immediately on reset assertion mid-ACCESS; a later mem_ack for that op SHALL be ignored.

Configuration
REQ-028 SHALL honour macro LSU_MISALIGN_TRAP_EN: defined -> misaligned op gets no mem_req, DONE with resp_err=1, wb_en=0, one cycle after accept.
REQ-029 SHALL, with LSU_MISALIGN_TRAP_EN undefined, clear offset low bits to natural alignment (offset & ~(size-1)) and complete normally with resp_err=0.

Verification
REQ-030 SHALL cover: LD addr=0x1008, mem_rdata=0x1122334455667788, ack 3 cycles after req -> mem_addr=0x1008, wb_data=0x1122334455667788, wb_en=1, resp_valid 1 cycle after ack.
REQ-031 SHALL cover: LB addr=0x2003, mem_rdata=0x00000000_80000000 -> wb_data=0xFFFFFFFFFFFFFF80; same with LBU -> 0x80.
REQ-032 SHALL cover: SH addr=0x3006, store_data=0xABCD -> mem_wstrb=0xC0, mem_wdata=0xABCD000000000000, mem_we=1, wb_en=0.
REQ-033 SHALL cover: LW addr=0x4002 -> with macro: no mem_req, resp_err=1; without: mem_addr=0x4000, wstrb=0, bytes [3:0] returned, resp_err=0.
REQ-034 SHALL cover: reset=0 two cycles into ACCESS, then ack pulse after release -> mem_req=0 immediately, no resp_valid, req_ready=1.
REQ-035 SHALL cover: LD with rd=0 -> resp_valid=1, wb_en=0; load funct3=111 -> resp_err=1, no mem_req.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store unit, IDLE -> ACCESS -> DONE handshake with a 64-bit data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned ops complete with resp_err instead of being aligned down.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_store, r_err, r_wb_en;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr, r_wdata, r_wb_data;
    logic [4:0]  r_rd;
    logic        w_accept, w_illegal, w_err;
    logic [2:0]  w_align, w_off;
    logic [7:0]  w_size_mask;
    logic [63:0] w_shifted, w_load;

    assign w_accept  = req_valid && r_state == IDLE;
    assign w_illegal = req_store ? funct3[2] : funct3 == 3'b111;
`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] w_req_align;
    assign w_req_align = 3'b111 << funct3[1:0];
    assign w_err = w_illegal || (addr[2:0] & ~w_req_align) != 3'b000;
`else
    assign w_err = w_illegal;
`endif
    // offset is forced down to natural alignment; with trapping enabled it is already aligned
    assign w_align     = 3'b111 << r_funct3[1:0];
    assign w_off       = r_addr[2:0] & w_align;
    assign w_size_mask = r_funct3[1] ? (r_funct3[0] ? 8'hFF : 8'h0F) : (r_funct3[0] ? 8'h03 : 8'h01);
    assign w_shifted   = mem_rdata >> {w_off, 3'b000};

    // Load result: pick the addressed field and sign/zero extend it
    always_comb begin
        w_load = w_shifted;
        case (r_funct3)
            3'b000:  w_load = {{56{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load = {56'd0, w_shifted[7:0]};
            3'b101:  w_load = {48'd0, w_shifted[15:0]};
            3'b110:  w_load = {32'd0, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    // FSM state register; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state: errors skip the memory access entirely
    always_comb begin
        w_next = r_state == IDLE   ? (w_accept ? (w_err ? DONE : ACCESS) : IDLE) :
                 r_state == ACCESS ? (mem_ack ? DONE : ACCESS) : IDLE;
    end

    // FSM outputs: memory request held stable from latched op for the whole ACCESS state
    always_comb begin
        req_ready  = r_state == IDLE;
        mem_req    = r_state == ACCESS;
        mem_we     = mem_req && r_store;
        mem_addr   = mem_req ? {r_addr[63:3], 3'b000} : 64'd0;
        mem_wdata  = mem_we ? r_wdata << {w_off, 3'b000} : 64'd0;
        mem_wstrb  = mem_we ? w_size_mask << w_off : 8'd0;
        resp_valid = r_state == DONE;
        resp_err   = resp_valid && r_err;
        wb_en      = resp_valid && r_wb_en;
        wb_rd      = r_rd;
        wb_data    = r_wb_data;
    end

    // Op latch on accept and response capture on memory acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= 64'd0;
            r_wdata   <= 64'd0;
            r_rd      <= 5'd0;
            r_err     <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_data <= 64'd0;
        end else if (w_accept) begin
            r_store   <= req_store;
            r_funct3  <= funct3;
            r_addr    <= addr;
            r_wdata   <= store_data;
            r_rd      <= rd;
            r_err     <= w_err;
            r_wb_en   <= 1'b0;
            r_wb_data <= 64'd0;
        end else if (r_state == ACCESS && mem_ack) begin
            r_wb_en   <= !r_store && r_rd != 5'd0;
            r_wb_data <= r_store ? 64'd0 : w_load;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte-level reference model.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0, store_data = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        req_ready, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        resp_valid, resp_err, wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    typedef struct {logic [63:0] a; logic [63:0] wd; logic [63:0] rdata; logic we; logic [7:0] strb; int lat;} mexp_t;
    typedef struct {logic err; logic wbe; logic [4:0] r; logic [63:0] data; int cyc;} rexp_t;
    mexp_t mq[$];
    rexp_t rq[$];
    int checks = 0, failures = 0, cyc = 0, pulses_req = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Reference model: access size in bytes, byte lanes, and field extraction by plain arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] sd, input logic [63:0] rdata, input logic [4:0] r,
                                  output logic err, output logic [63:0] ea, output logic [63:0] ewd,
                                  output logic [63:0] eld, output logic [7:0] estrb, output logic ewb);
        int n, lo, off;
        n   = 1 << f3[1:0];
        lo  = int'(a[2:0]);
        off = lo - (lo % n);
        err = st ? f3[2] : (f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (lo % n != 0) err = 1'b1;
`endif
        ea    = a & ~64'd7;
        ewd   = sd << (8 * off);
        estrb = 8'd0;
        eld   = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (st) estrb[off + i] = 1'b1;
            eld[8*i +: 8] = rdata[8*(off + i) +: 8];
        end
        if (!f3[2] && n < 8 && eld[8*n - 1])
            for (int j = 8 * n; j < 64; j++) eld[j] = 1'b1;
        ewb = !st && !err && r != 5'd0;
    endfunction

    // Push expectations and present the op until the accept edge has passed.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] r, input logic [63:0] rdata, input int lat);
        logic err, ewb;
        logic [63:0] ea, ewd, eld;
        logic [7:0] estrb;
        mexp_t m;
        rexp_t e;
        int k;
        model(st, f3, a, sd, rdata, r, err, ea, ewd, eld, estrb, ewb);
        k = 0;
        while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", k);
            finish_run();
        end
        if (!err) begin
            m.a = ea; m.wd = ewd; m.rdata = rdata; m.we = st; m.strb = estrb; m.lat = lat;
            mq.push_back(m);
        end
        e.err = err; e.wbe = ewb; e.r = r; e.data = eld;
        e.cyc = err ? cyc + 1 : cyc + 1 + lat + 1;
        rq.push_back(e);
        req_valid = 1'b1; req_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
        @(posedge clk); #1;
    endtask

    // Full op: keep req_valid high with junk while busy, so any wrong accept shows up.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] r, input logic [63:0] rdata, input int lat);
        int k;
        issue(st, f3, a, sd, r, rdata, lat);
        chk("ready_after_accept", 64'(req_ready), 64'd0);
        k = 0;
        while (rq.size() != 0 && k < 40) begin
            req_store = 1'($urandom_range(1)); funct3 = 3'($urandom_range(7));
            addr = {$urandom, $urandom}; store_data = {$urandom, $urandom}; rd = 5'($urandom_range(31));
            @(posedge clk); #1; k++;
        end
        req_valid = 1'b0;
        if (rq.size() != 0) begin
            checks++; failures++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles", k);
            finish_run();
        end
    endtask

    // Memory responder: checks each request against the expected queue and acks after its latency.
    initial begin
        mexp_t cur;
        bit busy, stray;
        int cnt, seen;
        busy = 0; cnt = 0; seen = 0;
        forever begin
            @(negedge clk);
            stray = 0;
            if (busy && !mem_req) busy = 0;
            if (mem_req && !busy) begin
                if (mq.size() == 0) begin
                    checks++; failures++; stray = 1;
                    $display("FAIL unexpected_mem_req: got addr %h we %b, required no request", mem_addr, mem_we);
                end else begin
                    cur = mq.pop_front(); cnt = cur.lat; busy = 1;
                end
            end
            if (stray) begin
                mem_ack = 1'b1; mem_rdata = 64'd0;
            end else if (busy) begin
                chk("mem_addr", mem_addr, cur.a);
                chk("mem_we", 64'(mem_we), 64'(cur.we));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(cur.strb));
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wd);
                if (cnt == 0) begin
                    mem_ack = 1'b1; mem_rdata = cur.rdata; busy = 0;
                end else cnt--;
            end else if (seen != pulses_req) begin
                seen++; mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
            end else if ($urandom_range(7) == 0) begin
                mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
    end

    // Response monitor: pops one expectation per resp_valid cycle.
    initial begin
        rexp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp: got resp_valid=1 err=%b wb_en=%b, required none", resp_err, wb_en);
                end else begin
                    e = rq.pop_front();
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("wb_en", 64'(wb_en), 64'(e.wbe));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.wbe) begin
                        chk("wb_rd", 64'(wb_rd), 64'(e.r));
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else if (wb_en) begin
                checks++; failures++;
                $display("FAIL wb_en_outside_done: got wb_en=1, required 0");
            end
        end
    end

    initial begin
        #600000;
        checks++; failures++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 3'd3, 64'h1008, 64'd0, 5'd5, 64'h1122334455667788, 3);
        do_op(1'b0, 3'd0, 64'h2003, 64'd0, 5'd6, 64'h0000000080000000, 0);
        do_op(1'b0, 3'd4, 64'h2003, 64'd0, 5'd6, 64'h0000000080000000, 1);
        do_op(1'b1, 3'd1, 64'h3006, 64'hABCD, 5'd7, 64'h0123456789ABCDEF, 1);
        do_op(1'b0, 3'd2, 64'h4002, 64'd0, 5'd8, 64'h8877665544332211, 2);
        do_op(1'b0, 3'd3, 64'h5000, 64'd0, 5'd0, 64'hDEADBEEFCAFEF00D, 0);
        do_op(1'b0, 3'd7, 64'h6000, 64'd0, 5'd9, 64'h0, 0);
        do_op(1'b1, 3'd5, 64'h7000, 64'h55, 5'd9, 64'h0, 0);
        // reset in the middle of an access; the late ack must not resurrect the op
        issue(1'b0, 3'd3, 64'h8000, 64'd0, 5'd10, 64'h1, 50);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_addr", mem_addr, 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        rq.delete();
        mq.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        pulses_req++;
        repeat (4) begin
            @(posedge clk); #1;
            chk("postrst_req_ready", 64'(req_ready), 64'd1);
            chk("postrst_mem_req", 64'(mem_req), 64'd0);
        end
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(1)), 3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(31)), {$urandom, $urandom}, $urandom_range(3));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        finish_run();
    end
endmodule
